// File: rtl/pcm_packer_pkg.sv
// rtl/pcm_packer_pkg.sv - shared FSM states, default marker and sizing helper for the PCM frame packer
package pcm_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_DATA
    } pack_state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h00AAFF00;

    function automatic int bytes_per_sample(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// rtl/sync_byte_fifo.sv - single-clock byte FIFO with registered read data, count and registered flags
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_rd_en,
    output logic [7:0]               o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    r_rd_data;
    logic          r_full;
    logic          r_empty;
    logic          w_do_wr;
    logic          w_do_rd;

    assign w_do_rd = i_rd_en && (r_count != '0);
    assign w_do_wr = i_wr_en && ((r_count != CW'(DEPTH)) || w_do_rd);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/pcm_frame_packer.sv
// rtl/pcm_frame_packer.sv - serialises PCM frames into a byte FIFO with periodic sync marker; PCM_PACKER_SEQ_EN adds a per-frame sequence byte
module pcm_frame_packer
    import pcm_packer_pkg::*;
#(
    parameter int          SAMPLE_BITS = 24,
    parameter int          NUM_CH      = 2,
    parameter int          FIFO_DEPTH  = 131072,
    parameter int          SYNC_PERIOD = 127,
    parameter logic [31:0] SYNC_WORD   = DEFAULT_SYNC_WORD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_strobe_i,
    input  logic [NUM_CH*SAMPLE_BITS-1:0] samples_i,
    input  logic                          rd_req_i,
    output logic [7:0]                    byte_o,
    output logic                          byte_valid_o,
    output logic                          fifo_full_o,
    output logic                          fifo_empty_o,
    output logic [15:0]                   overflow_cnt_o
);
    localparam int BPS        = bytes_per_sample(SAMPLE_BITS);
    localparam int LANE_W     = BPS * 8;
    localparam int DATA_BYTES = NUM_CH * BPS;
    localparam int IDX_W      = $clog2(DATA_BYTES + 1);
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int NW         = CW + 1;
    localparam int SCW        = $clog2(SYNC_PERIOD);
`ifdef PCM_PACKER_SEQ_EN
    localparam int          SEQ_BYTES  = 1;
    localparam pack_state_t FIRST_BODY = ST_SEQ;
`else
    localparam int          SEQ_BYTES  = 0;
    localparam pack_state_t FIRST_BODY = ST_DATA;
`endif

    logic [2:0]                 r_sync;
    pack_state_t                r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [DATA_BYTES*8-1:0]    r_frame;
    logic [SCW-1:0]             r_sync_cnt;
    logic [15:0]                r_ovf;
`ifdef PCM_PACKER_SEQ_EN
    logic [7:0]                 r_seq_cnt;
`endif
    logic                       r_rd_pend;
    logic                       r_rd_hit;
    logic [7:0]                 r_byte;
    logic                       r_byte_valid;

    logic                       w_event;
    logic                       w_sync_due;
    logic [NW-1:0]              w_fb;
    logic                       w_accept;
    logic [DATA_BYTES*8-1:0]    w_ext;
    logic [7:0]                 w_wr_data;
    logic                       w_wr_en;
    logic                       w_rd_accept;
    logic                       w_pop;
    logic [7:0]                 w_rd_data;
    logic [CW-1:0]              w_count;

    assign w_event    = r_sync[1] & ~r_sync[2];
    assign w_sync_due = (r_sync_cnt == '0);
    assign w_fb       = NW'(DATA_BYTES + SEQ_BYTES) + (w_sync_due ? NW'(BPS) : '0);
    // Free space is judged on the pre-read count, so a same-cycle pop never helps admission.
    assign w_accept   = w_event && (r_state == ST_IDLE) &&
                        (({1'b0, w_count} + w_fb) <= NW'(FIFO_DEPTH));
    assign w_wr_en    = (r_state != ST_IDLE);

    always_comb begin
        w_ext = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ext[c*LANE_W +: LANE_W] = LANE_W'(signed'(samples_i[c*SAMPLE_BITS +: SAMPLE_BITS]));
        end
    end

    always_comb begin
        w_wr_data = '0;
        case (r_state)
            ST_SYNC: begin
                for (int b = 0; b < BPS; b++) begin
                    if (r_idx == IDX_W'(b)) w_wr_data = SYNC_WORD[b*8 +: 8];
                end
            end
`ifdef PCM_PACKER_SEQ_EN
            ST_SEQ:  w_wr_data = r_seq_cnt;
`endif
            ST_DATA: begin
                for (int b = 0; b < DATA_BYTES; b++) begin
                    if (r_idx == IDX_W'(b)) w_wr_data = r_frame[b*8 +: 8];
                end
            end
            default: w_wr_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], frame_strobe_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_frame    <= '0;
            r_sync_cnt <= '0;
            r_ovf      <= '0;
`ifdef PCM_PACKER_SEQ_EN
            r_seq_cnt  <= '0;
`endif
        end else begin
            if (w_event && !w_accept && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_frame    <= w_ext;
                        r_idx      <= '0;
                        r_sync_cnt <= (r_sync_cnt == SCW'(SYNC_PERIOD - 1)) ? '0 : r_sync_cnt + SCW'(1);
                        r_state    <= w_sync_due ? ST_SYNC : FIRST_BODY;
                    end
                end
                ST_SYNC: begin
                    if (r_idx == IDX_W'(BPS - 1)) begin
                        r_idx   <= '0;
                        r_state <= FIRST_BODY;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
`ifdef PCM_PACKER_SEQ_EN
                ST_SEQ: begin
                    r_seq_cnt <= r_seq_cnt + 8'd1;
                    r_state   <= ST_DATA;
                end
`endif
                ST_DATA: begin
                    if (r_idx == IDX_W'(DATA_BYTES - 1)) begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_rd_accept = rd_req_i & ~r_rd_pend;
    assign w_pop       = w_rd_accept & (w_count != '0);

    // Two register stages: FIFO read register, then the output byte register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_pend    <= 1'b0;
            r_rd_hit     <= 1'b0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_rd_pend    <= w_rd_accept;
            r_rd_hit     <= w_pop;
            r_byte_valid <= r_rd_pend;
            r_byte       <= r_rd_hit ? w_rd_data : 8'h00;
        end
    end

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_full    (fifo_full_o),
        .o_empty   (fifo_empty_o)
    );

    assign byte_o         = r_byte;
    assign byte_valid_o   = r_byte_valid;
    assign overflow_cnt_o = r_ovf;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// tb/tb_pcm_frame_packer.sv - directed self-checking bench for pcm_frame_packer over four parameter sets
module tb_pcm_frame_packer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  strobe;
    logic [3:0]  rd_req;
    logic [47:0] samples;
    logic [11:0] samples_d;
    logic [7:0]  bo   [4];
    logic        bv   [4];
    logic        bf   [4];
    logic        be   [4];
    logic [15:0] ovf  [4];

    int          n_cmp;
    int          n_bad;
    logic [7:0]  exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: defaults
    pcm_frame_packer u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_strobe_i(strobe[0]), .samples_i(samples),
        .rd_req_i(rd_req[0]), .byte_o(bo[0]), .byte_valid_o(bv[0]),
        .fifo_full_o(bf[0]), .fifo_empty_o(be[0]), .overflow_cnt_o(ovf[0]));

    // B: short sync period
    pcm_frame_packer #(.SYNC_PERIOD(3), .FIFO_DEPTH(64)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_strobe_i(strobe[1]), .samples_i(samples),
        .rd_req_i(rd_req[1]), .byte_o(bo[1]), .byte_valid_o(bv[1]),
        .fifo_full_o(bf[1]), .fifo_empty_o(be[1]), .overflow_cnt_o(ovf[1]));

    // C: tiny FIFO for whole-frame admission
    pcm_frame_packer #(.FIFO_DEPTH(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .frame_strobe_i(strobe[2]), .samples_i(samples),
        .rd_req_i(rd_req[2]), .byte_o(bo[2]), .byte_valid_o(bv[2]),
        .fifo_full_o(bf[2]), .fifo_empty_o(be[2]), .overflow_cnt_o(ovf[2]));

    // D: 12-bit mono, exercises sign extension into 16-bit lanes
    pcm_frame_packer #(.SAMPLE_BITS(12), .NUM_CH(1), .FIFO_DEPTH(16)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .frame_strobe_i(strobe[3]), .samples_i(samples_d),
        .rd_req_i(rd_req[3]), .byte_o(bo[3]), .byte_valid_o(bv[3]),
        .fifo_full_o(bf[3]), .fifo_empty_o(be[3]), .overflow_cnt_o(ovf[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input int k);
        @(negedge clk) strobe[k] = 1'b1;
        repeat (4) @(negedge clk);
        strobe[k] = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic read_check(input int k, input logic [7:0] exp, input string tag);
        @(negedge clk) rd_req[k] = 1'b1;
        @(negedge clk) rd_req[k] = 1'b0;
        check({tag, ".early"}, 32'(bv[k]), 32'd0);
        @(negedge clk);
        check({tag, ".valid"}, 32'(bv[k]), 32'd1);
        check({tag, ".byte"}, 32'(bo[k]), 32'(exp));
    endtask

    task automatic drain_check(input int k, input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            read_check(k, exp_q[i], $sformatf("%s%0d", tag, i));
        end
        check({tag, ".empty_after"}, 32'(be[k]), 32'd1);
        exp_q.delete();
    endtask

    task automatic push_frame(input bit sync, input logic [7:0] seq,
                              input logic [23:0] c0, input logic [23:0] c1);
        if (sync) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hAA);
        end
`ifdef PCM_PACKER_SEQ_EN
        exp_q.push_back(seq);
`endif
        for (int i = 0; i < 3; i++) exp_q.push_back(c0[i*8 +: 8]);
        for (int i = 0; i < 3; i++) exp_q.push_back(c1[i*8 +: 8]);
    endtask

    initial begin
        logic [23:0] c0;
        logic [23:0] c1;
        n_cmp     = 0;
        n_bad     = 0;
        strobe    = '0;
        rd_req    = '0;
        samples   = '0;
        samples_d = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst.byte",  32'(bo[0]),  32'h00);
        check("rst.valid", 32'(bv[0]),  32'd0);
        check("rst.full",  32'(bf[0]),  32'd0);
        check("rst.empty", 32'(be[0]),  32'd1);
        check("rst.ovf",   32'(ovf[0]), 32'd0);

        // Basic frame: 00 FF AA 56 34 12 BA DC FE
        samples = {24'hFEDCBA, 24'h123456};
        send_frame(0);
        check("basic.empty", 32'(be[0]), 32'd0);
        check("basic.full",  32'(bf[0]), 32'd0);
        push_frame(1'b1, 8'h00, 24'h123456, 24'hFEDCBA);
        drain_check(0, "basic.b");

        read_check(0, 8'h00, "emptyrd");
        check("emptyrd.empty", 32'(be[0]), 32'd1);

        // Reset during DATA: strobe raised at n0, state is DATA by n7
        @(negedge clk) strobe[0] = 1'b1;
        repeat (4) @(negedge clk);
        strobe[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.busy_empty", 32'(be[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.byte",  32'(bo[0]),  32'h00);
        check("midrst.valid", 32'(bv[0]),  32'd0);
        check("midrst.full",  32'(bf[0]),  32'd0);
        check("midrst.empty", 32'(be[0]),  32'd1);
        check("midrst.ovf",   32'(ovf[0]), 32'd0);
        repeat (4) @(negedge clk);
        check("midrst.quiet", 32'(be[0]), 32'd1);
        samples = {24'h00ABCD, 24'h7FFFFF};
        send_frame(0);
        push_frame(1'b1, 8'h00, 24'h7FFFFF, 24'h00ABCD);
        drain_check(0, "postrst.b");

        // Sync periodicity: marker before frames 1, 4, 7
        for (int f = 1; f <= 7; f++) begin
            c0 = 24'h102030 + 24'(f);
            c1 = 24'hC0FFEE - 24'(f);
            samples = {c1, c0};
            push_frame((f % 3) == 1, 8'(f - 1), c0, c1);
            send_frame(1);
        end
        check("period.ovf", 32'(ovf[1]), 32'd0);
        drain_check(1, "period.b");

        // Whole-frame admission into a 16-byte FIFO
        samples = {24'hFEDCBA, 24'h123456};
        for (int f = 0; f < 4; f++) send_frame(2);
`ifdef PCM_PACKER_SEQ_EN
        check("admit.ovf", 32'(ovf[2]), 32'd3);
        push_frame(1'b1, 8'h00, 24'h123456, 24'hFEDCBA);
`else
        check("admit.ovf", 32'(ovf[2]), 32'd2);
        push_frame(1'b1, 8'h00, 24'h123456, 24'hFEDCBA);
        push_frame(1'b0, 8'h01, 24'h123456, 24'hFEDCBA);
`endif
        check("admit.full", 32'(bf[2]), 32'd0);
        drain_check(2, "admit.b");

        // Sign extension: 12'h9AB -> F9AB, 12'h7FF -> 07FF
        samples_d = 12'h9AB;
        send_frame(3);
        samples_d = 12'h7FF;
        send_frame(3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
`ifdef PCM_PACKER_SEQ_EN
        exp_q.push_back(8'h00);
`endif
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hF9);
`ifdef PCM_PACKER_SEQ_EN
        exp_q.push_back(8'h01);
`endif
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h07);
        drain_check(3, "sext.b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcm_frame_packer.md
# pcm_frame_packer

Parametrised capture-side packer between the I2S receive/decimation chain and the SPI slave. It takes multichannel PCM frames arriving from the slow I2S clock domain, serialises each frame into bytes with an optional periodic sync marker, and buffers them in an internal byte FIFO. Whole-frame admission prevents partial frames from reaching the FIFO. Byte requests from the SPI side are served on a fixed-latency handshake.

## Interface
- `SAMPLE_BITS`, 24: valid bits per channel sample, 8..32.
- `NUM_CH`, 2: channels per frame, 1..8.
- `FIFO_DEPTH`, 131072: byte FIFO depth, power of two.
- `SYNC_PERIOD`, 127: accepted frames per sync marker, ≥2.
- `SYNC_WORD`, 32'h00AAFF00: marker; low `BPS*8` bits used. `BPS = ceil(SAMPLE_BITS/8)`.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_strobe_i` in 1: asynchronous frame-ready level from the I2S domain; high ≥3 `clk` cycles.
- `samples_i` in `NUM_CH*SAMPLE_BITS`: channel 0 in the LSBs; stable while strobe high.
- `rd_req_i` in 1: one-cycle pulse requesting one byte.
- `byte_o` out 8: returned byte.
- `byte_valid_o` out 1: one-cycle pulse qualifying `byte_o`.
- `fifo_full_o` out 1: FIFO full.
- `fifo_empty_o` out 1: FIFO empty.
- `overflow_cnt_o` out 16: dropped frames, saturating at 16'hFFFF.

## Operation
- **Strobe sync and capture:** 3-flop synchroniser on the strobe; a rising edge on synchronised stages [2:1] is a frame event. On the event, `samples_i` is captured into a frame register. Each sample is sign-extended to `BPS*8` bits.
- **Frame layout:**
  - If the sync counter is 0: `SYNC_WORD`, `BPS` bytes, LSB first.
  - Then the samples, channel 0 first, each `BPS` bytes, LSB first.
  - Frame bytes `FB = NUM_CH*BPS`, plus `BPS` when sync is due.
- **Admission:** accept only if state is IDLE and FIFO free count ≥ `FB`. Otherwise drop the whole frame and increment `overflow_cnt_o` (saturating). The sync counter is not advanced on a drop.
- **Sync counter:** advances on each accepted frame and wraps at `SYNC_PERIOD-1`. The first frame after reset carries sync.
- **FSM states:**
  - `IDLE` → `SYNC` when an accepted frame has sync due; otherwise → `DATA`.
  - `SYNC` emits `BPS` bytes, then → `SEQ` (if configured) or `DATA`.
  - `SEQ` emits 1 byte, then → `DATA`.
  - `DATA` emits `NUM_CH*BPS` bytes, then → `IDLE`.
  - Exactly one FIFO write per cycle in non-IDLE states. Admission guarantees a write is never blocked.
- **Read side:** `rd_req_i` with FIFO non-empty pops one byte; with FIFO empty returns 8'h00 and pops nothing.
  - A request arriving while the previous one is still pending is ignored.
- **Simultaneous events:** a FIFO write and read in the same cycle are both performed, and the count is unchanged. A full FIFO with a read pending in the same cycle still refuses admission, because free space is evaluated before the read.
- **Reset** (also mid-frame): FSM to IDLE, FIFO emptied, partial frame discarded, sync counter and overflow counter cleared, synchroniser cleared.
- **Reset values:** `byte_o`=0, `byte_valid_o`=0, `fifo_full_o`=0, `fifo_empty_o`=1, `overflow_cnt_o`=0.

## Timing
- Strobe rise to frame event: 3–4 `clk` cycles.
- Frame event at cycle N: capture at N, first FIFO write at N+1, last write at N+FB. `fifo_empty_o` falls at N+2.
- `rd_req_i` at cycle R: `byte_valid_o` and `byte_o` at R+2, for both the empty and non-empty cases.
- `fifo_full_o` and `fifo_empty_o` are registered; they reflect the count one cycle after the write or read.

## Configuration
- `PCM_PACKER_SEQ_EN` defined:
  - Every frame carries a `SEQ` byte holding an 8-bit accepted-frame counter (wraps 255→0, reset 0).
  - The byte follows the sync marker, or comes first when there is no marker.
  - `FB` grows by 1.
- `PCM_PACKER_SEQ_EN` undefined: no `SEQ` state and no counter logic.

## Structure
- Package `pcm_packer_pkg`:
  - FSM state enum: IDLE, SYNC, SEQ, DATA.
  - Default `SYNC_WORD` constant.
  - Function `bytes_per_sample(bits)`.
- Sub-module `sync_byte_fifo`: single-clock, 8-bit, depth `FIFO_DEPTH`, one-cycle registered read, count output. It is instantiated once.

## Test plan
- **Basic frame, defaults:** samples ch0=24'h123456, ch1=24'hFEDCBA, first strobe → FIFO holds 00 FF AA 56 34 12 BA DC FE. Reads return these bytes in order, each at R+2.
- **Sync periodicity:** `SYNC_PERIOD`=3, 7 frames → sync precedes frames 1, 4, 7 only. Total bytes = 7*6 + 3*3 = 51.
- **Whole-frame admission:** `FIFO_DEPTH`=16, no reads, 4 frames → frame 1 = 9 bytes, frame 2 = 6 bytes, frames 3–4 dropped. Result: count 15, `overflow_cnt_o`=2, no partial frame stored.
- **Empty read:** `rd_req_i` on an empty FIFO → `byte_o`=8'h00 with `byte_valid_o` at R+2, `fifo_empty_o` stays 1.
- **Reset mid-frame:** `rst_n` low 1 cycle during the `DATA` state → all outputs at their reset values. The next frame starts with the sync marker.
- **SEQ option:** `PCM_PACKER_SEQ_EN`, `SAMPLE_BITS`=16, `NUM_CH`=1, 300 frames → seq bytes 00..FF, then wrap to 00..2B.
